sprite_draw_sequencer: RTL and testbench

Parametrised draw sequencer for up to N_CH sprite channels (enemies, projectiles) sharing one VGA write port. On a draw request from the game control FSM it grants each enabled channel in ascending index order, forwards that channel's pixel stream to the VGA side through one register stage, and signals completion once all enabled channels have finished. It adds per-channel enable masking, a watchdog timeout and abort-on-drop behaviour. It sits between the per-sprite drawing modules and the VGA write arbiter.

---
 rtl/sprite_draw_sequencer_pkg.sv | 26 ++
 rtl/sprite_draw_sequencer_if.sv | 44 ++++
 rtl/sprite_draw_sequencer_next_enabled_finder.sv | 30 +++
 rtl/sprite_draw_sequencer.sv | 174 +++++++++++++++++
 tb/tb_sprite_draw_sequencer.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_draw_sequencer_pkg.sv
// Shared types and defaults for the sprite draw sequencer: FSM state
// encoding, default bus widths and the ON/OFF levels used for strobes.
package sprite_draw_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_ACTIVE = 2'd2,
    S_DONE   = 2'd3
  } seq_state_e;

  localparam int DEF_N_CH    = 3;
  localparam int DEF_X_W     = 9;
  localparam int DEF_Y_W     = 8;
  localparam int DEF_C_W     = 6;
  localparam int DEF_MAX_CYC = 1024;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  // Channel index width; a single channel still needs one bit.
  function automatic int idx_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/sprite_draw_sequencer_if.sv
// Bundle of the control, per-channel sprite and VGA write signals around the
// sequencer. The master side is the game control plus sprite drawers plus
// VGA arbiter; the slave side is the sequencer itself.
interface sprite_draw_sequencer_if
  import sprite_draw_sequencer_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int X_W  = DEF_X_W,
  parameter int Y_W  = DEF_Y_W,
  parameter int C_W  = DEF_C_W
);

  // Control side
  logic                draw;
  logic [N_CH-1:0]     ch_enable;
  logic                draw_done;
  logic                busy;
  logic [N_CH-1:0]     timeout_err;

  // Flattened per-channel sprite streams, channel i at [i*W +: W]
  logic [N_CH*X_W-1:0] ch_x_draw;
  logic [N_CH*Y_W-1:0] ch_y_draw;
  logic [N_CH*C_W-1:0] ch_colour;
  logic [N_CH-1:0]     ch_write;
  logic [N_CH-1:0]     ch_done;
  logic [N_CH-1:0]     ch_draw;

  // VGA write port
  logic [X_W-1:0]      x_draw;
  logic [Y_W-1:0]      y_draw;
  logic [C_W-1:0]      colour;
  logic                VGA_write;

  modport master (
    output draw, ch_enable, ch_x_draw, ch_y_draw, ch_colour, ch_write, ch_done,
    input  draw_done, busy, timeout_err, ch_draw, x_draw, y_draw, colour, VGA_write
  );

  modport slave (
    input  draw, ch_enable, ch_x_draw, ch_y_draw, ch_colour, ch_write, ch_done,
    output draw_done, busy, timeout_err, ch_draw, x_draw, y_draw, colour, VGA_write
  );

endinterface

// File: rtl/sprite_draw_sequencer_next_enabled_finder.sv
// Priority scan: lowest set bit of mask_i at or above start_i. Once the
// sequence has stepped past the last channel (exhausted_i) nothing is found,
// which also covers an index counter that wrapped back to zero.
module next_enabled_finder
  import sprite_draw_sequencer_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int IDX_W = idx_width(DEF_N_CH)
) (
  input  logic [N_CH-1:0]  mask_i,
  input  logic [IDX_W-1:0] start_i,
  input  logic             exhausted_i,
  output logic [IDX_W-1:0] index_o,
  output logic             valid_o
);

  // Descending loop so the last hit written is the lowest qualifying index.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    index_o = '0;
    valid_o = OFF;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (!exhausted_i && mask_i[i] && (IDX_W'(i) >= start_i)) begin
        index_o = IDX_W'(i);
        valid_o = ON;
      end
    end
  end

endmodule

// File: rtl/sprite_draw_sequencer.sv
// Grants each enabled sprite channel in ascending order, forwards the granted
// channel's pixel stream to the VGA port through one register stage, skips a
// channel that overruns its watchdog and reports completion to control.
module sprite_draw_sequencer
  import sprite_draw_sequencer_pkg::*;
#(
  parameter int N_CH    = DEF_N_CH,
  parameter int X_W     = DEF_X_W,
  parameter int Y_W     = DEF_Y_W,
  parameter int C_W     = DEF_C_W,
  parameter int MAX_CYC = DEF_MAX_CYC
) (
  input  logic                  clock,
  input  logic                  reset,
  sprite_draw_sequencer_if.slave bus
);

  localparam int IDX_W  = idx_width(N_CH);
  localparam int WDOG_W = $clog2(MAX_CYC + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(MAX_CYC - 1);

  seq_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              past_end_q, past_end_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [N_CH-1:0]   mask_q, mask_d;
  logic [N_CH-1:0]   terr_q, terr_d;

  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  logic [C_W-1:0]    colour_q;
  logic              write_q;

  logic [IDX_W-1:0]  found_idx;
  logic              found_valid;

  logic [X_W-1:0]    sel_x;
  logic [Y_W-1:0]    sel_y;
  logic [C_W-1:0]    sel_colour;
  logic              sel_write;
  logic              sel_done;

  next_enabled_finder #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_finder (
    .mask_i      (mask_q),
    .start_i     (idx_q),
    .exhausted_i (past_end_q),
    .index_o     (found_idx),
    .valid_o     (found_valid)
  );

  // Pick the granted channel's fields out of the flattened buses.
  always_comb begin
    sel_x      = '0;
    sel_y      = '0;
    sel_colour = '0;
    sel_write  = OFF;
    sel_done   = OFF;
    for (int i = 0; i < N_CH; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_x      = bus.ch_x_draw[i*X_W +: X_W];
        sel_y      = bus.ch_y_draw[i*Y_W +: Y_W];
        sel_colour = bus.ch_colour[i*C_W +: C_W];
        sel_write  = bus.ch_write[i];
        sel_done   = bus.ch_done[i];
      end
    end
  end

  // State and sequencing registers.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      past_end_q <= OFF;
      wdog_q     <= '0;
      mask_q     <= '0;
      terr_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      past_end_q <= past_end_d;
      wdog_q     <= wdog_d;
      mask_q     <= mask_d;
      terr_q     <= terr_d;
    end
  end

  // Next-state logic: request latch, channel scan, watchdog and abort.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    past_end_d = past_end_q;
    wdog_d     = wdog_q;
    mask_d     = mask_q;
    terr_d     = terr_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.draw) begin
          mask_d     = bus.ch_enable;
          idx_d      = '0;
          past_end_d = OFF;
          state_d    = S_SELECT;
        end
      end
      S_SELECT: begin
        if (!bus.draw) begin
          state_d = S_IDLE;
        end else if (found_valid) begin
          idx_d   = found_idx;
          wdog_d  = '0;
          state_d = S_ACTIVE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_ACTIVE: begin
        if (!bus.draw) begin
          state_d = S_IDLE;
        end else if (sel_done || (wdog_q == WDOG_LAST)) begin
          // A channel finishing on its last allowed cycle is not an error.
          if (!sel_done) begin
            terr_d = terr_q | (N_CH'(1) << idx_q);
          end
          {past_end_d, idx_d} = {1'b0, idx_q} + (IDX_W + 1)'(1);
          state_d = S_SELECT;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      S_DONE: begin
        if (!bus.draw) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Decoded outputs: one-hot grant, completion and busy flags.
  always_comb begin
    bus.ch_draw   = (state_q == S_ACTIVE) ? (N_CH'(1) << idx_q) : '0;
    bus.draw_done = (state_q == S_DONE);
    bus.busy      = (state_q != S_IDLE);
  end

  // One-stage pixel register toward the VGA arbiter; coordinates hold when idle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      write_q  <= OFF;
    end else if (state_q == S_ACTIVE) begin
      x_q      <= sel_x;
      y_q      <= sel_y;
      colour_q <= sel_colour;
      write_q  <= sel_write;
    end else begin
      write_q  <= OFF;
    end
  end

  assign bus.x_draw      = x_q;
  assign bus.y_draw      = y_q;
  assign bus.colour      = colour_q;
  assign bus.VGA_write   = write_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_sprite_draw_sequencer.sv
// Directed bench for sprite_draw_sequencer with three channels and an
// eight-cycle watchdog. Pixels driven on the channel side are pushed to a
// scoreboard and popped when VGA_write appears one cycle later.
module tb_sprite_draw_sequencer;

  localparam int N_CH    = 3;
  localparam int X_W     = 9;
  localparam int Y_W     = 8;
  localparam int C_W     = 6;
  localparam int MAX_CYC = 8;

  typedef struct {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] c;
    int             cyc;
  } pix_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;
  int   vga_count;
  logic saw_010;
  int   gcount;
  pix_t sb[$];

  sprite_draw_sequencer_if #(.N_CH(N_CH), .X_W(X_W), .Y_W(Y_W), .C_W(C_W)) bus ();

  sprite_draw_sequencer #(
    .N_CH    (N_CH),
    .X_W     (X_W),
    .Y_W     (Y_W),
    .C_W     (C_W),
    .MAX_CYC (MAX_CYC)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Channel ch presents n pixels on consecutive cycles, done on the last one.
  task automatic drive_pixels(input int ch, input int n);
    pix_t p;
    for (int j = 0; j < n; j++) begin
      p.x   = X_W'(ch * 40 + j * 3 + 1);
      p.y   = Y_W'(ch * 20 + j + 5);
      p.c   = C_W'(ch * 8 + j + 1);
      p.cyc = cyc + 1;
      bus.ch_x_draw[ch*X_W +: X_W] = p.x;
      bus.ch_y_draw[ch*Y_W +: Y_W] = p.y;
      bus.ch_colour[ch*C_W +: C_W] = p.c;
      bus.ch_write = N_CH'(1 << ch);
      bus.ch_done  = (j == n - 1) ? N_CH'(1 << ch) : '0;
      sb.push_back(p);
      tick();
    end
    bus.ch_write = '0;
    bus.ch_done  = '0;
  endtask

  // Scoreboard consumer and grant observer, sampled on the falling edge.
  always @(negedge clk) begin : monitor
    pix_t e;
    if (rst_n) begin
      if (bus.ch_draw == 3'b010) saw_010 = 1'b1;
      if (bus.VGA_write) begin
        vga_count++;
        if (sb.size() == 0) begin
          check("vga_unexpected_write", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("vga_x", 32'(bus.x_draw), 32'(e.x));
          check("vga_y", 32'(bus.y_draw), 32'(e.y));
          check("vga_colour", 32'(bus.colour), 32'(e.c));
          check("vga_latency_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    vga_count = 0;
    saw_010   = 1'b0;
    gcount    = 0;
    rst_n     = 1'b0;
    bus.draw      = 1'b0;
    bus.ch_enable = '0;
    bus.ch_x_draw = '0;
    bus.ch_y_draw = '0;
    bus.ch_colour = '0;
    bus.ch_write  = '0;
    bus.ch_done   = '0;
    repeat (3) tick();

    // Reset values
    check("rst_ch_draw", 32'(bus.ch_draw), 32'd0);
    check("rst_x", 32'(bus.x_draw), 32'd0);
    check("rst_y", 32'(bus.y_draw), 32'd0);
    check("rst_colour", 32'(bus.colour), 32'd0);
    check("rst_vga_write", 32'(bus.VGA_write), 32'd0);
    check("rst_draw_done", 32'(bus.draw_done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // All three channels, four pixels each
    bus.ch_enable = 3'b111;
    bus.draw      = 1'b1;
    tick();
    check("s1_select_busy", 32'(bus.busy), 32'd1);
    check("s1_select_no_grant", 32'(bus.ch_draw), 32'd0);
    tick();
    check("s1_grant_ch0", 32'(bus.ch_draw), 32'b001);
    bus.ch_enable = 3'b000;  // must be ignored until the next request
    drive_pixels(0, 4);
    check("s1_handoff0_gap", 32'(bus.ch_draw), 32'd0);
    tick();
    check("s1_grant_ch1", 32'(bus.ch_draw), 32'b010);
    drive_pixels(1, 4);
    check("s1_handoff1_gap", 32'(bus.ch_draw), 32'd0);
    tick();
    check("s1_grant_ch2", 32'(bus.ch_draw), 32'b100);
    drive_pixels(2, 4);
    check("s1_done_not_yet", 32'(bus.draw_done), 32'd0);
    check("s1_busy_select", 32'(bus.busy), 32'd1);
    tick();
    check("s1_draw_done", 32'(bus.draw_done), 32'd1);
    check("s1_done_no_grant", 32'(bus.ch_draw), 32'd0);
    tick();
    check("s1_draw_done_held", 32'(bus.draw_done), 32'd1);
    bus.draw = 1'b0;
    tick();
    check("s1_draw_done_drop", 32'(bus.draw_done), 32'd0);
    check("s1_idle_busy", 32'(bus.busy), 32'd0);
    check("s1_vga_count", 32'(vga_count), 32'd12);
    check("s1_scoreboard_drained", 32'(sb.size()), 32'd0);

    // Mask 101: channel 1 skipped with no extra cycles
    saw_010       = 1'b0;
    bus.ch_enable = 3'b101;
    bus.draw      = 1'b1;
    tick();
    tick();
    check("s2_grant_ch0", 32'(bus.ch_draw), 32'b001);
    drive_pixels(0, 2);
    check("s2_handoff_gap", 32'(bus.ch_draw), 32'd0);
    tick();
    check("s2_grant_ch2", 32'(bus.ch_draw), 32'b100);
    drive_pixels(2, 2);
    tick();
    check("s2_draw_done", 32'(bus.draw_done), 32'd1);
    check("s2_ch1_never_granted", 32'(saw_010), 32'd0);
    bus.draw = 1'b0;
    tick();

    // Empty mask completes straight away
    bus.ch_enable = 3'b000;
    bus.draw      = 1'b1;
    tick();
    check("s3_select_no_grant", 32'(bus.ch_draw), 32'd0);
    check("s3_select_not_done", 32'(bus.draw_done), 32'd0);
    tick();
    check("s3_draw_done_cycle2", 32'(bus.draw_done), 32'd1);
    check("s3_no_grant", 32'(bus.ch_draw), 32'd0);
    bus.draw = 1'b0;
    tick();
    check("s3_draw_done_drop", 32'(bus.draw_done), 32'd0);

    // Watchdog: channel 1 never finishes
    bus.ch_enable = 3'b111;
    bus.draw      = 1'b1;
    tick();
    tick();
    check("s4_grant_ch0", 32'(bus.ch_draw), 32'b001);
    drive_pixels(0, 1);
    tick();
    check("s4_grant_ch1", 32'(bus.ch_draw), 32'b010);
    gcount = 0;
    for (int t = 0; t < 20 && bus.ch_draw == 3'b010; t++) begin
      gcount++;
      tick();
    end
    check("s4_ch1_grant_cycles", 32'(gcount), 32'(MAX_CYC));
    check("s4_gap_after_timeout", 32'(bus.ch_draw), 32'd0);
    check("s4_timeout_err", 32'(bus.timeout_err), 32'b010);
    tick();
    check("s4_grant_ch2", 32'(bus.ch_draw), 32'b100);
    drive_pixels(2, 1);
    tick();
    check("s4_draw_done", 32'(bus.draw_done), 32'd1);
    check("s4_timeout_err_kept", 32'(bus.timeout_err), 32'b010);
    bus.draw = 1'b0;
    tick();

    // Abort while channel 1 is active, then restart from channel 0
    bus.draw = 1'b1;
    tick();
    tick();
    check("s5_grant_ch0", 32'(bus.ch_draw), 32'b001);
    drive_pixels(0, 1);
    tick();
    check("s5_grant_ch1", 32'(bus.ch_draw), 32'b010);
    tick();
    bus.draw = 1'b0;
    tick();
    check("s5_abort_no_grant", 32'(bus.ch_draw), 32'd0);
    check("s5_abort_busy", 32'(bus.busy), 32'd0);
    check("s5_abort_no_done", 32'(bus.draw_done), 32'd0);
    tick();
    check("s5_abort_still_no_done", 32'(bus.draw_done), 32'd0);
    bus.draw = 1'b1;
    tick();
    tick();
    check("s5_restart_ch0", 32'(bus.ch_draw), 32'b001);
    check("s5_timeout_err_sticky", 32'(bus.timeout_err), 32'b010);

    // Reset while active with an error bit set
    rst_n = 1'b0;
    tick();
    check("s6_rst_ch_draw", 32'(bus.ch_draw), 32'd0);
    check("s6_rst_x", 32'(bus.x_draw), 32'd0);
    check("s6_rst_y", 32'(bus.y_draw), 32'd0);
    check("s6_rst_colour", 32'(bus.colour), 32'd0);
    check("s6_rst_vga_write", 32'(bus.VGA_write), 32'd0);
    check("s6_rst_draw_done", 32'(bus.draw_done), 32'd0);
    check("s6_rst_busy", 32'(bus.busy), 32'd0);
    check("s6_rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    bus.draw = 1'b0;
    rst_n    = 1'b1;
    tick();
    tick();
    check("s6_idle_after_reset", 32'(bus.busy), 32'd0);
    check("final_scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
